// File: rtl/std_mem_arbiter_pkg.sv
// Shared types and helpers for the two-requester memory arbiter.
package std_mem_arbiter_pkg;

  // Identifies which requester a tag (and thus a read result) belongs to.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  // Width needed to hold an occupancy count from 0 up to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/std_mem_intf.sv
// Valid/ready memory stream: one command or result beat per transfer.
interface std_mem_intf #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              write_enable;
  logic              read_enable;
  logic [MASK_W-1:0] mask;

  // Sink side: receives the beat, drives back-pressure.
  modport in (
    input  valid, addr, data, write_enable, read_enable, mask,
    output ready
  );

  // Source side: drives the beat, observes back-pressure.
  modport out (
    output valid, addr, data, write_enable, read_enable, mask,
    input  ready
  );

endinterface

// File: rtl/std_mem_arbiter_tag_fifo.sv
// Tag FIFO: remembers which requester issued each read still in flight,
// in issue order, so results can be steered back to their owner.
module std_mem_arbiter_tag_fifo
  import std_mem_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  port_id_e         i_push_id,
  input  logic             i_pop,
  output port_id_e         o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  port_id_e         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Qualify push/pop so a misbehaving caller can never overrun or underrun.
  always_comb begin
    w_push = i_push & ~o_full;
    w_pop  = i_pop & ~o_empty;
  end

  // Pointer, occupancy and storage update; pointers wrap modulo DEPTH (power of two).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= PORT0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/std_mem_arbiter.sv
// Two-requester memory arbiter with a registered command stage and an
// in-order tag FIFO that steers read results back to their requester.
// Optional build macro: STD_MEM_ARBITER_FIXED_PRIORITY_EN -- when defined,
// port 0 always wins a conflict and no last-grant pointer is kept.
module std_mem_arbiter
  import std_mem_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  std_mem_intf.in   command0,
  std_mem_intf.in   command1,
  std_mem_intf.out  result0,
  std_mem_intf.out  result1,
  std_mem_intf.out  mem_command,
  std_mem_intf.in   mem_result
);

  localparam int ADDR_W = $bits(mem_command.addr);
  localparam int DATA_W = $bits(mem_command.data);
  localparam int MASK_W = $bits(mem_command.mask);
  localparam int CNT_W  = cnt_width(TAG_DEPTH);

  // Elaboration-time guard: all six streams must agree on field widths,
  // and the tag depth must be a power of two of at least 2.
  generate
    if ($bits(command0.addr) != ADDR_W || $bits(command1.addr) != ADDR_W ||
        $bits(result0.addr)  != ADDR_W || $bits(result1.addr)  != ADDR_W ||
        $bits(mem_result.addr) != ADDR_W ||
        $bits(command0.data) != DATA_W || $bits(command1.data) != DATA_W ||
        $bits(result0.data)  != DATA_W || $bits(result1.data)  != DATA_W ||
        $bits(mem_result.data) != DATA_W ||
        $bits(command0.mask) != MASK_W || $bits(command1.mask) != MASK_W ||
        $bits(result0.mask)  != MASK_W || $bits(result1.mask)  != MASK_W ||
        $bits(mem_result.mask) != MASK_W) begin : g_width_mismatch
      $error("std_mem_arbiter: interface addr/data/mask widths do not match");
    end
    if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_depth_bad
      $error("std_mem_arbiter: TAG_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Output stage registers
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_we;
  logic              r_out_re;
  logic [MASK_W-1:0] r_out_mask;

  // Tag FIFO connections
  port_id_e          w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  port_id_e          w_push_id;
  logic              w_pop;

  // Arbitration wires
  logic w_stage_free;
  logic w_rd_block;
  logic w_no_tag;
  logic w_can0;
  logic w_can1;
  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;

`ifndef STD_MEM_ARBITER_FIXED_PRIORITY_EN
  port_id_e r_last_grant;
`endif

  // Admission conditions; the full/empty views are cross-checked against the
  // count so a single corrupted flag cannot let a read overrun the FIFO.
  always_comb begin
    w_stage_free = ~r_out_valid | mem_command.ready;
    w_rd_block   = w_fifo_full | (w_count >= CNT_W'(TAG_DEPTH));
    w_no_tag     = w_fifo_empty | (w_count == {CNT_W{1'b0}});
    w_can0       = rst & w_stage_free & ~(command0.read_enable & w_rd_block);
    w_can1       = rst & w_stage_free & ~(command1.read_enable & w_rd_block);
    w_req0       = command0.valid & w_can0;
    w_req1       = command1.valid & w_can1;
  end

  // Grant selection among eligible requesters.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
`ifdef STD_MEM_ARBITER_FIXED_PRIORITY_EN
    if (w_req0) begin
      w_gnt0 = 1'b1;
    end else if (w_req1) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
`else
    if (w_req0 && w_req1) begin
      if (r_last_grant == PORT0) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b1;
      end
    end else if (w_req0) begin
      w_gnt0 = 1'b1;
    end else if (w_req1) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
`endif
  end

  // A requester is ready only if it could be accepted and the other one is not taking the slot.
  assign command0.ready = w_can0 & ~w_gnt1;
  assign command1.ready = w_can1 & ~w_gnt0;

  // Tag bookkeeping: reads record their owner, result transfers retire the oldest tag.
  always_comb begin
    w_push    = (w_gnt0 & command0.read_enable) | (w_gnt1 & command1.read_enable);
    w_push_id = w_gnt1 ? PORT1 : PORT0;
    w_pop     = mem_result.valid & mem_result.ready & ~w_no_tag;
  end

  // Command output stage: load on grant, clear when drained, otherwise hold fields stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= {ADDR_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
      r_out_we    <= 1'b0;
      r_out_re    <= 1'b0;
      r_out_mask  <= {MASK_W{1'b0}};
    end else if (w_gnt0) begin
      r_out_valid <= 1'b1;
      r_out_addr  <= command0.addr;
      r_out_data  <= command0.data;
      r_out_we    <= command0.write_enable;
      r_out_re    <= command0.read_enable;
      r_out_mask  <= command0.mask;
    end else if (w_gnt1) begin
      r_out_valid <= 1'b1;
      r_out_addr  <= command1.addr;
      r_out_data  <= command1.data;
      r_out_we    <= command1.write_enable;
      r_out_re    <= command1.read_enable;
      r_out_mask  <= command1.mask;
    end else if (mem_command.ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

`ifndef STD_MEM_ARBITER_FIXED_PRIORITY_EN
  // Round-robin memory: remember the last winner; starts at port 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= PORT1;
    end else if (w_gnt0) begin
      r_last_grant <= PORT0;
    end else if (w_gnt1) begin
      r_last_grant <= PORT1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  assign mem_command.valid        = r_out_valid;
  assign mem_command.addr         = r_out_addr;
  assign mem_command.data         = r_out_data;
  assign mem_command.write_enable = r_out_we;
  assign mem_command.read_enable  = r_out_re;
  assign mem_command.mask         = r_out_mask;

  // Result steering: only the head-tag owner sees valid; with no tag the beat is absorbed.
  always_comb begin
    result0.valid = mem_result.valid & ~w_no_tag & (w_head == PORT0);
    result1.valid = mem_result.valid & ~w_no_tag & (w_head == PORT1);
    if (w_no_tag) begin
      mem_result.ready = 1'b1;
    end else if (w_head == PORT0) begin
      mem_result.ready = result0.ready;
    end else begin
      mem_result.ready = result1.ready;
    end
  end

  assign result0.addr         = mem_result.addr;
  assign result0.data         = mem_result.data;
  assign result0.write_enable = mem_result.write_enable;
  assign result0.read_enable  = mem_result.read_enable;
  assign result0.mask         = mem_result.mask;
  assign result1.addr         = mem_result.addr;
  assign result1.data         = mem_result.data;
  assign result1.write_enable = mem_result.write_enable;
  assign result1.read_enable  = mem_result.read_enable;
  assign result1.mask         = mem_result.mask;

  std_mem_arbiter_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_push    (w_push),
    .i_push_id (w_push_id),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

endmodule
